// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Decodes access size, lane enables and store-data replication.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] r;
    unique case (f3[1:0])
      2'b00:   r = 4'b0001 << a;
      2'b01:   r = 4'b0011 << a;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] r;
    unique case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Data-memory bus: valid/ack request with byte enables.
// master = load/store unit, slave = memory.
interface lsu_controller_if;

  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busByteEn;
  logic        busAck;
  logic [31:0] busRdata;

  modport master (
    output busReq,
    output busWe,
    output busAddr,
    output busWdata,
    output busByteEn,
    input  busAck,
    input  busRdata
  );

  modport slave (
    input  busReq,
    input  busWe,
    input  busAddr,
    input  busWdata,
    input  busByteEn,
    output busAck,
    output busRdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane of a bus read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {addr, 3'b000};
    data = '0;
    unique case (1'b1)
      func3 == F3_B:  data = {{24{lane[7]}}, lane[7:0]};
      func3 == F3_H:  data = {{16{lane[15]}}, lane[15:0]};
      func3 == F3_W:  data = rdata;
      func3 == F3_BU: data = {24'b0, lane[7:0]};
      func3 == F3_HU: data = {16'b0, lane[15:0]};
      default:        data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: runs one bus access per request,
// stalls the pipeline, reports misalign/size/timeout errors.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        func3,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic              stall,
  output logic [31:0]       readData,
  output logic              accessError,
  output logic [1:0]        errorCode,
  lsu_controller_if.master  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      nxt;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [1:0]  err_q;
  logic [1:0]  err_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        req;
  logic        in_req;
  logic        in_done;
  logic [31:0] ld_word;

  assign req = memRead | memWrite;

  always_comb begin
    nxt   = state;
    err_d = err_q;
    cnt_d = cnt_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          cnt_d = '0;
          if (f3_illegal(memWrite, func3)) begin
            nxt   = DONE;
            err_d = ERR_SIZE;
          end else if (misaligned(func3, address[1:0])) begin
            nxt   = DONE;
            err_d = ERR_MISALIGN;
          end else begin
            nxt   = REQ;
            err_d = ERR_NONE;
          end
        end
      end
      REQ: begin
        // ack wins over timeout in the final allowed cycle
        if (bus.busAck) begin
          nxt = DONE;
        end else if (cnt_q == TO_LAST) begin
          nxt   = DONE;
          err_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt_q <= '0;
      err_q <= ERR_NONE;
      a_q   <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
      f3_q  <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= nxt;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (state == IDLE && req) begin
        a_q  <= address;
        wd_q <= writeData;
        f3_q <= func3;
        we_q <= memWrite;
      end
      if (state == REQ && bus.busAck)
        rd_q <= bus.busRdata;
    end
  end

  lsu_load_align u_align (
    .rdata (rd_q),
    .addr  (a_q[1:0]),
    .func3 (f3_q),
    .data  (ld_word)
  );

  assign in_req  = (state == REQ);
  assign in_done = (state == DONE);

  assign stall = ~reset &
                 (in_req | ((state == IDLE) & req));

  assign bus.busReq    = in_req;
  assign bus.busWe     = in_req & we_q;
  assign bus.busAddr   = in_req ? {a_q[31:2], 2'b00} : '0;
  assign bus.busByteEn = in_req ? byte_en(f3_q, a_q[1:0]) : '0;
  assign bus.busWdata  = in_req ? store_data(f3_q, wd_q) : '0;

  assign readData = (in_done && err_q == ERR_NONE && !we_q)
                    ? ld_word : '0;
  assign accessError = in_done && (err_q != ERR_NONE);
  assign errorCode   = in_done ? err_q : ERR_NONE;

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: directed vector table, reset and
// random accesses checked against a byte-level reference model.
module tb_lsu_controller;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        stall;
  logic [31:0] readData;
  logic        accessError;
  logic [1:0]  errorCode;

  lsu_controller_if bif();

  lsu_controller #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .func3       (func3),
    .address     (address),
    .writeData   (writeData),
    .stall       (stall),
    .readData    (readData),
    .accessError (accessError),
    .errorCode   (errorCode),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          d;
    logic [31:0] rdata;
    int          e_stall;
    int          e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic [1:0]  e_err;
  } vec_t;

  typedef struct {
    int          nstall;
    int          nreq;
    logic [31:0] baddr;
    logic [31:0] bwd;
    logic [3:0]  be;
    logic        bwe;
    logic        stable;
    logic [31:0] rd;
    logic        aerr;
    logic [1:0]  ec;
    logic        done;
  } obs_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one access; ack is driven d cycles after the first
  // REQ cycle, whatever state the DUT is in by then.
  task automatic run_access(input vec_t v, output obs_t o);
    o.nstall = 0; o.nreq = 0; o.baddr = '0; o.bwd = '0;
    o.be = '0; o.bwe = 1'b0; o.stable = 1'b1; o.rd = '0;
    o.aerr = 1'b0; o.ec = '0; o.done = 1'b0;
    @(negedge clk);
    memWrite = v.we;
    memRead = !v.we;
    func3 = v.f3;
    address = v.addr;
    writeData = v.wd;
    bif.busAck = 1'($urandom % 2);
    bif.busRdata = $urandom;
    for (int cyc = 0; cyc < 64 && !o.done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        memRead = 1'b0;
        memWrite = 1'b0;
        func3 = 3'($urandom);
        address = $urandom;
        writeData = $urandom;
        bif.busAck = (cyc == v.d + 1);
        bif.busRdata = (cyc == v.d + 1) ? v.rdata : $urandom;
      end
      #1;
      if (stall) o.nstall++;
      if (bif.busReq) begin
        if (o.nreq == 0) begin
          o.baddr = bif.busAddr; o.bwd = bif.busWdata;
          o.be = bif.busByteEn; o.bwe = bif.busWe;
        end else if (o.baddr !== bif.busAddr ||
                     o.bwd !== bif.busWdata ||
                     o.be !== bif.busByteEn ||
                     o.bwe !== bif.busWe) begin
          o.stable = 1'b0;
        end
        o.nreq++;
      end
      if (cyc > 0 && !stall) begin
        o.done = 1'b1;
        o.rd = readData;
        o.aerr = accessError;
        o.ec = errorCode;
      end
    end
  endtask

  task automatic compare(input string tag, input vec_t v,
                         input obs_t o);
    check({tag, ".done"}, 32'(o.done), 32'd1);
    check({tag, ".stall"}, o.nstall, v.e_stall);
    check({tag, ".req"}, o.nreq, v.e_req);
    if (v.e_req > 0) begin
      check({tag, ".addr"}, o.baddr, v.addr & 32'hFFFF_FFFC);
      check({tag, ".be"}, 32'(o.be), 32'(v.e_be));
      check({tag, ".we"}, 32'(o.bwe), 32'(v.we));
      check({tag, ".stable"}, 32'(o.stable), 32'd1);
      if (v.we) check({tag, ".wdata"}, o.bwd, v.e_wd);
    end
    check({tag, ".rdata"}, o.rd, v.e_rd);
    check({tag, ".aerr"}, 32'(o.aerr), 32'(v.e_err != 2'b00));
    check({tag, ".ecode"}, 32'(o.ec), 32'(v.e_err));
  endtask

  // Reference: works on byte counts and lane offsets.
  function automatic vec_t model(input logic we,
                                 input logic [2:0] f3,
                                 input logic [31:0] addr,
                                 input logic [31:0] wd,
                                 input int d,
                                 input logic [31:0] rdata);
    vec_t v;
    int n, off;
    bit bad, mis;
    longint val;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.d = d; v.rdata = rdata;
    v.e_be = '0; v.e_wd = '0; v.e_rd = '0;
    if (we) bad = (f3 > 3'd2);
    else bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f3[1:0];
    off = int'(addr % 4);
    mis = !bad && ((off % n) != 0);
    if (bad || mis) begin
      v.e_err = bad ? 2'b10 : 2'b01;
      v.e_stall = 1;
      v.e_req = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        v.e_be[i] = (i >= off) && (i < off + n);
        v.e_wd[i*8 +: 8] = wd[(i % n)*8 +: 8];
      end
      if (d >= TO) begin
        v.e_err = 2'b11;
        v.e_stall = 1 + TO;
        v.e_req = TO;
      end else begin
        v.e_err = 2'b00;
        v.e_stall = d + 2;
        v.e_req = d + 1;
        if (!we) begin
          val = longint'(rdata >> (8 * off));
          val = val & ((64'd1 << (8 * n)) - 1);
          if (!f3[2] && n < 4 && val >= (64'd1 << (8 * n - 1)))
            val = val - (64'd1 << (8 * n));
          v.e_rd = val[31:0];
        end
      end
    end
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    obs_t o;
    logic [2:0] legal_ld [5];
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    bif.busAck = 1'b0;
    bif.busRdata = '0;

    // reset state, with a request pending to show stall gating
    reset = 1'b1;
    memRead = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.busReq", 32'(bif.busReq), 32'd0);
    check("rst.busWe", 32'(bif.busWe), 32'd0);
    check("rst.busAddr", bif.busAddr, 32'd0);
    check("rst.busWdata", bif.busWdata, 32'd0);
    check("rst.busByteEn", 32'(bif.busByteEn), 32'd0);
    check("rst.readData", readData, 32'd0);
    check("rst.accessError", 32'(accessError), 32'd0);
    check("rst.errorCode", 32'(errorCode), 32'd0);
    memRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // we f3 addr wd d rdata | stall req be wdata rdata err
    tbl.push_back('{1'b0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF,
                    2, 1, 4'hF, 32'h0, 32'hDEADBEEF, 2'b00});
    tbl.push_back('{1'b0, F3_B, 32'h103, 32'h0, 0, 32'h80123456,
                    2, 1, 4'h8, 32'h0, 32'hFFFFFF80, 2'b00});
    tbl.push_back('{1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80123456,
                    2, 1, 4'h8, 32'h0, 32'h00000080, 2'b00});
    tbl.push_back('{1'b1, F3_H, 32'h202, 32'h0000ABCD, 3, 32'h0,
                    5, 4, 4'hC, 32'hABCDABCD, 32'h0, 2'b00});
    tbl.push_back('{1'b0, F3_W, 32'h101, 32'h0, 0, 32'h0,
                    1, 0, 4'h0, 32'h0, 32'h0, 2'b01});
    tbl.push_back('{1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0,
                    1, 0, 4'h0, 32'h0, 32'h0, 2'b10});
    tbl.push_back('{1'b0, F3_W, 32'h300, 32'h0, 4, 32'h12345678,
                    5, 4, 4'hF, 32'h0, 32'h0, 2'b11});
    tbl.push_back('{1'b0, F3_H, 32'h102, 32'h0, 1, 32'h80010000,
                    3, 2, 4'hC, 32'h0, 32'hFFFF8001, 2'b00});
    tbl.push_back('{1'b1, F3_BU, 32'h0, 32'h0, 0, 32'h0,
                    1, 0, 4'h0, 32'h0, 32'h0, 2'b10});
    tbl.push_back('{1'b0, 3'b111, 32'h1, 32'h0, 0, 32'h0,
                    1, 0, 4'h0, 32'h0, 32'h0, 2'b10});
    tbl.push_back('{1'b1, F3_B, 32'h5, 32'h12345678, 0, 32'h0,
                    2, 1, 4'h2, 32'h78787878, 32'h0, 2'b00});
    tbl.push_back('{1'b0, F3_HU, 32'h2, 32'h0, 3, 32'hFFFF0000,
                    5, 4, 4'hC, 32'h0, 32'h0000FFFF, 2'b00});
    tbl.push_back('{1'b1, F3_W, 32'h106, 32'h0, 0, 32'h0,
                    1, 0, 4'h0, 32'h0, 32'h0, 2'b01});

    foreach (tbl[i]) begin
      run_access(tbl[i], o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // reset while a load waits in REQ
    @(negedge clk);
    bif.busAck = 1'b0;
    memRead = 1'b1;
    func3 = F3_W;
    address = 32'h100;
    @(negedge clk);
    memRead = 1'b0;
    #1;
    check("midrst.pre_req", 32'(bif.busReq), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst.busReq", 32'(bif.busReq), 32'd0);
    check("midrst.busAddr", bif.busAddr, 32'd0);
    check("midrst.busByteEn", 32'(bif.busByteEn), 32'd0);
    check("midrst.stall", 32'(stall), 32'd0);
    reset = 1'b0;
    v = '{1'b0, F3_W, 32'h100, 32'h0, 1, 32'hCAFEF00D,
          3, 2, 4'hF, 32'h0, 32'hCAFEF00D, 2'b00};
    run_access(v, o);
    compare("midrst.after", v, o);

    // random back-to-back traffic against the model
    for (int k = 0; k < 120; k++) begin
      logic we;
      logic [2:0] f3;
      we = 1'($urandom % 2);
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom % 3);
      else f3 = legal_ld[$urandom % 5];
      v = model(we, f3, $urandom, $urandom,
                int'($urandom % 7), $urandom);
      run_access(v, o);
      compare($sformatf("rnd%0d", k), v, o);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
